present_arb: RTL and testbench
==============================

Name: present_arb

Overview:
- Shares one PRESENT-80 encryption core between two independent requesters.
- Accepts a plaintext/key job from either requester over a valid/ready handshake, using round-robin arbitration.
- Drives the core's start pulse and holds the core's plaintext/key inputs stable for the whole job. Waits for the core's ready flag, captures the ciphertext and returns it to the granted requester.
- Sits between client logic and the core. Exactly one job is in flight at a time.

Parameters:
- TMO, 40, watchdog limit in cycles for BUSY (used only with PRESENT_ARB_TMO_EN).
- RDY_SKIP, 1, cycles after the start pulse during which cs_rdy is ignored (covers core rdy deassert latency).

Ports:
- ck  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- rq_vld  input  2  job request valid, bit i = requester i
- rq_rdy  output  2  job accepted when rq_vld[i]&rq_rdy[i]
- rq_inp0  input  64  [0:63] plaintext, requester 0
- rq_key0  input  80  [0:79] key, requester 0
- rq_inp1  input  64  [0:63] plaintext, requester 1
- rq_key1  input  80  [0:79] key, requester 1
- rs_vld  output  2  result valid, one-hot, bit i = requester i
- rs_rdy  input  2  result consumed when rs_vld[i]&rs_rdy[i]
- rs_out  output  64  [0:63] ciphertext (shared, qualified by rs_vld)
- rs_err  output  1  qualifies rs_vld: job timed out, rs_out = 0
- cs_sta  output  1  core start pulse
- cs_inp  output  64  [0:63] core plaintext
- cs_key  output  80  [0:79] core key
- cs_rdy  input  1  core ready flag
- cs_out  input  64  [0:63] core ciphertext
- busy  output  1  high in every state except IDLE

Behaviour:
- Clock and reset: one clock ck; reset rst is synchronous and active-high. Reset is sampled at the rising edge of ck and overrides all other inputs.
- Reset values:
  - FSM returns to IDLE.
  - Outputs forced low: rq_rdy=0 is overridden only by the IDLE grant; rs_vld=0, rs_err=0, cs_sta=0, busy=0.
  - Zeroed: rs_out=0, cs_inp=0, cs_key=0, job/result registers.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
- Reset mid-job: the job is silently dropped. No response is issued. cs_sta stays 0, so the core is simply abandoned; its next sta restarts it.
- FSM states: IDLE, LAUNCH, BUSY, DONE.
- IDLE:
  - Grant g is combinational. If only one rq_vld bit is set, g is that bit. If both are set, g = ~last.
  - rq_rdy[g]=1 only in IDLE and only when rq_vld[g]=1; the other bit is 0.
  - On handshake: capture the granted inp/key into cs_inp/cs_key registers, register g, go to LAUNCH.
  - rq_* inputs are ignored in every other state (rq_rdy=00).
- LAUNCH: cs_sta=1 for exactly this one cycle; go to BUSY and clear the cycle counter.
- BUSY:
  - The counter increments every cycle.
  - cs_rdy is ignored while counter < RDY_SKIP.
  - After that, the first cycle with cs_rdy=1 captures cs_out into rs_out and goes to DONE.
- DONE:
  - rs_vld[g]=1 is registered, high from the cycle after capture.
  - rs_out and rs_vld hold stable until rs_rdy[g]=1.
  - On that handshake: last<=g, rs_vld<=0, go to IDLE.
  - rs_rdy[~g] is ignored.
- cs_inp/cs_key: change only on the IDLE accept and are stable through LAUNCH/BUSY/DONE.
- Latency:
  - Accept at edge T; cs_sta is high during cycle T+1.
  - Result capture occurs at the edge where cs_rdy is seen; rs_vld is high in the following cycle.
  - The minimum accept-to-next-accept gap is LAUNCH + BUSY + DONE cycles. No back-to-back overlap.
- Simultaneous events:
  - A new rq_vld arriving in DONE waits; it is not accepted in the same cycle as the rs handshake (IDLE is entered first).
  - Both requesters holding rq_vld continuously are served alternately, 0,1,0,1...
- Counter width: ceil(log2(TMO+1))+1 bits. The counter saturates and never wraps.

Optional Feature:
- Macro: PRESENT_ARB_TMO_EN.
- With the macro defined:
  - If BUSY lasts TMO cycles without an accepted cs_rdy, go to DONE with rs_out=0 and rs_err=1 alongside rs_vld[g].
  - rs_err clears with the rs handshake.
- Without the macro: there is no watchdog, BUSY waits indefinitely, and rs_err is tied to 0.

Test Plan:
- Single job: reset, then requester 0 sends inp=0, key=0. Required: cs_sta pulses 1 cycle after accept; rs_vld=01; rs_out=5579C1387B228445; cs_key holds 0 throughout.
- Tie break:
  - Stimulus: rq_vld=11 with inp0=0/key0=0 and inp1=FFFFFFFFFFFFFFFF/key1=FFFFFFFFFFFFFFFFFFFF; both vld held.
  - Required: first grant is 0, second is 1. Requester 1 receives 3333DCD3213210D2.
- Backpressure: rs_rdy=00 for 20 cycles in DONE -> rs_vld and rs_out stable, rq_rdy=00, busy=1; release -> IDLE next cycle.
- Handshake stability: change rq_inp0 during BUSY -> cs_inp unchanged, result matches the originally accepted plaintext.
- Reset mid-BUSY: assert rst 5 cycles after cs_sta -> next cycle all outputs at reset values; a fresh job completes correctly.
- Timeout (PRESENT_ARB_TMO_EN, TMO=40, core model holds cs_rdy=0) -> rs_vld=01, rs_err=1, rs_out=0 at cycle 41 of BUSY; without the macro -> busy stays 1 indefinitely.

Source files
------------

// File: rtl/present_arb.sv
// present_arb: shares one PRESENT-80 core between two requesters.
// Round-robin grant in IDLE; one job in flight; the result returns to the granted requester.
// Optional BUSY watchdog enabled by defining PRESENT_ARB_TMO_EN.
module present_arb #(
  parameter int unsigned TMO      = 40,
  parameter int unsigned RDY_SKIP = 1
) (
  input  logic        ck,
  input  logic        rst,
  input  logic [1:0]  rq_vld,
  output logic [1:0]  rq_rdy,
  input  logic [0:63] rq_inp0,
  input  logic [0:79] rq_key0,
  input  logic [0:63] rq_inp1,
  input  logic [0:79] rq_key1,
  output logic [1:0]  rs_vld,
  input  logic [1:0]  rs_rdy,
  output logic [0:63] rs_out,
  output logic        rs_err,
  output logic        cs_sta,
  output logic [0:63] cs_inp,
  output logic [0:79] cs_key,
  input  logic        cs_rdy,
  input  logic [0:63] cs_out,
  output logic        busy
);

  localparam int unsigned CW = $clog2(TMO + 1) + 1;
  localparam logic [CW-1:0] SkipCnt = CW'(RDY_SKIP);
`ifdef PRESENT_ARB_TMO_EN
  localparam logic [CW-1:0] TmoLast = CW'(TMO - 1);
`endif

  typedef enum logic [1:0] {StIdle, StLaunch, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic          last_q, last_d;
  logic          gnt_q, gnt_d;
  logic          grant;
  logic          rdy_ok;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [0:63]   inp_q, inp_d;
  logic [0:79]   key_q, key_d;
  logic [0:63]   out_q, out_d;
`ifdef PRESENT_ARB_TMO_EN
  logic          err_q, err_d;
`endif

  // Round-robin grant: a lone request wins outright, a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    unique case (rq_vld)
      2'b10:   grant = 1'b1;
      2'b11:   grant = ~last_q;
      default: grant = 1'b0;
    endcase
  end

  // Core ready only counts once the core has had time to drop its stale ready flag.
  assign rdy_ok = cs_rdy && (cnt_q >= SkipCnt);

  // Next-state logic and handshake/start outputs.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    gnt_d   = gnt_q;
    cnt_d   = cnt_q;
    inp_d   = inp_q;
    key_d   = key_q;
    out_d   = out_q;
`ifdef PRESENT_ARB_TMO_EN
    err_d   = err_q;
`endif
    rq_rdy  = 2'b00;
    cs_sta  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (rq_vld[grant]) begin
          rq_rdy[grant] = 1'b1;
          gnt_d         = grant;
          inp_d         = grant ? rq_inp1 : rq_inp0;
          key_d         = grant ? rq_key1 : rq_key0;
          state_d       = StLaunch;
        end
      end
      StLaunch: begin
        cs_sta  = 1'b1;
        cnt_d   = '0;
        state_d = StBusy;
      end
      StBusy: begin
        // Saturate rather than wrap so a long wait can never re-open the skip window.
        if (cnt_q != '1) cnt_d = cnt_q + CW'(1);
        if (rdy_ok) begin
          out_d   = cs_out;
`ifdef PRESENT_ARB_TMO_EN
          err_d   = 1'b0;
`endif
          state_d = StDone;
        end
`ifdef PRESENT_ARB_TMO_EN
        else if (cnt_q >= TmoLast) begin
          out_d   = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end
`endif
      end
      StDone: begin
        if (rs_rdy[gnt_q]) begin
          last_d  = gnt_q;
`ifdef PRESENT_ARB_TMO_EN
          err_d   = 1'b0;
`endif
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers, synchronous reset.
  always_ff @(posedge ck) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      gnt_q   <= 1'b0;
      cnt_q   <= '0;
      inp_q   <= '0;
      key_q   <= '0;
      out_q   <= '0;
`ifdef PRESENT_ARB_TMO_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
      inp_q   <= inp_d;
      key_q   <= key_d;
      out_q   <= out_d;
`ifdef PRESENT_ARB_TMO_EN
      err_q   <= err_d;
`endif
    end
  end

  // Result valid is one-hot on the granted requester while in DONE.
  always_comb begin
    rs_vld = 2'b00;
    if (state_q == StDone) rs_vld[gnt_q] = 1'b1;
  end

  assign rs_out = out_q;
  assign cs_inp = inp_q;
  assign cs_key = key_q;
  assign busy   = (state_q != StIdle);
`ifdef PRESENT_ARB_TMO_EN
  assign rs_err = err_q;
`else
  assign rs_err = 1'b0;
`endif

endmodule

// File: tb/tb_present_arb.sv
// Directed, table-driven bench for present_arb with a lookup-table PRESENT core model.
module tb_present_arb;

  localparam logic [0:63] Z64 = 64'h0;
  localparam logic [0:63] F64 = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [0:79] Z80 = 80'h0;
  localparam logic [0:79] F80 = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
  localparam logic [0:63] C00 = 64'h5579C1387B228445;
  localparam logic [0:63] C0F = 64'hE72C46C0F5945049;
  localparam logic [0:63] CF0 = 64'hA112FFC72F68417B;
  localparam logic [0:63] CFF = 64'h3333DCD3213210D2;
  localparam int unsigned Lat = 8;

  logic        ck = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  rq_vld = 2'b00;
  logic [1:0]  rq_rdy;
  logic [0:63] rq_inp0 = '0;
  logic [0:79] rq_key0 = '0;
  logic [0:63] rq_inp1 = '0;
  logic [0:79] rq_key1 = '0;
  logic [1:0]  rs_vld;
  logic [1:0]  rs_rdy = 2'b00;
  logic [0:63] rs_out;
  logic        rs_err;
  logic        cs_sta;
  logic [0:63] cs_inp;
  logic [0:79] cs_key;
  logic        cs_rdy = 1'b1;
  logic [0:63] cs_out = 64'hDEAD_BEEF_DEAD_BEEF;
  logic        busy;

  int errors = 0;
  int checks = 0;

  logic        hang = 1'b0;
  logic        sta_q = 1'b0;
  int unsigned core_cnt = 0;

  always #5 ck = ~ck;

  present_arb #(.TMO(40), .RDY_SKIP(1)) dut (
    .ck(ck), .rst(rst),
    .rq_vld(rq_vld), .rq_rdy(rq_rdy),
    .rq_inp0(rq_inp0), .rq_key0(rq_key0), .rq_inp1(rq_inp1), .rq_key1(rq_key1),
    .rs_vld(rs_vld), .rs_rdy(rs_rdy), .rs_out(rs_out), .rs_err(rs_err),
    .cs_sta(cs_sta), .cs_inp(cs_inp), .cs_key(cs_key), .cs_rdy(cs_rdy), .cs_out(cs_out),
    .busy(busy)
  );

  function automatic logic [0:63] present_lut(input logic [0:63] p, input logic [0:79] k);
    if (p == Z64 && k == Z80) return C00;
    if (p == Z64 && k == F80) return C0F;
    if (p == F64 && k == Z80) return CF0;
    if (p == F64 && k == F80) return CFF;
    return 64'h0123_4567_89AB_CDEF;
  endfunction

  // Core model: ready drops one cycle late after start, result appears Lat cycles later.
  always @(posedge ck) begin
    sta_q <= cs_sta;
    if (sta_q) begin
      cs_rdy   <= 1'b0;
      cs_out   <= 64'hDEAD_BEEF_DEAD_BEEF;
      core_cnt <= Lat;
    end else if (core_cnt != 0) begin
      core_cnt <= core_cnt - 1;
      if (core_cnt == 1 && !hang) begin
        cs_rdy <= 1'b1;
        cs_out <= present_lut(cs_inp, cs_key);
      end
    end
  end

  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rq_rdy"}, rq_rdy, 2'b00);
    chk({tag, "_rs_vld"}, rs_vld, 2'b00);
    chk({tag, "_rs_err"}, rs_err, 1'b0);
    chk({tag, "_cs_sta"}, cs_sta, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_rs_out"}, rs_out, Z64);
    chk({tag, "_cs_inp"}, cs_inp, Z64);
    chk({tag, "_cs_key"}, cs_key, Z80);
  endtask

  // Polls the current cycle for a handshake; returns with the accepting edge still ahead.
  task automatic wait_accept(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if ((rq_vld & rq_rdy) != 2'b00) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic run_job(input logic [1:0] vld, input logic [0:63] i0, input logic [0:79] k0,
                         input logic [0:63] i1, input logic [0:79] k1, input logic eg,
                         input logic [0:63] eout, input bit hold, input int bp);
    bit          ok;
    logic [1:0]  ev;
    logic [0:63] ei;
    logic [0:79] ek;
    ev = eg ? 2'b10 : 2'b01;
    ei = eg ? i1 : i0;
    ek = eg ? k1 : k0;
    rq_vld = vld; rq_inp0 = i0; rq_key0 = k0; rq_inp1 = i1; rq_key1 = k1;
    #1;
    wait_accept(ok);
    if (!ok) begin fail("accept"); return; end
    chk("grant", rq_rdy, ev);
    step();
    if (!hold) rq_vld = 2'b00;
    // Scramble requester data after acceptance; the core must still see the accepted job.
    rq_inp0 = ~i0; rq_key0 = ~k0; rq_inp1 = ~i1; rq_key1 = ~k1;
    chk("launch_sta", cs_sta, 1'b1);
    chk("launch_inp", cs_inp, ei);
    chk("launch_key", cs_key, ek);
    chk("launch_busy", busy, 1'b1);
    chk("launch_rq_rdy", rq_rdy, 2'b00);
    step();
    chk("sta_pulse_end", cs_sta, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (rs_vld != 2'b00) begin ok = 1'b1; break; end
      step();
    end
    if (!ok) begin fail("result"); return; end
    chk("rs_vld", rs_vld, ev);
    chk("rs_out", rs_out, eout);
    chk("rs_err", rs_err, 1'b0);
    chk("done_inp", cs_inp, ei);
    chk("done_key", cs_key, ek);
    rs_rdy = ~ev;
    for (int i = 0; i < bp; i++) begin
      step();
      chk("bp_rs_vld", rs_vld, ev);
      chk("bp_rs_out", rs_out, eout);
      chk("bp_rq_rdy", rq_rdy, 2'b00);
      chk("bp_busy", busy, 1'b1);
    end
    rs_rdy = ev;
    step();
    rs_rdy = 2'b00;
    chk("release_busy", busy, 1'b0);
    chk("release_rs_vld", rs_vld, 2'b00);
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic [0:63] i0;
    logic [0:79] k0;
    logic [0:63] i1;
    logic [0:79] k1;
    logic        g;
    logic [0:63] out;
  } vec_t;

  vec_t vecs[8];

  initial begin
    bit ok;
    vecs[0] = '{vld: 2'b01, i0: Z64, k0: Z80, i1: Z64, k1: Z80, g: 1'b0, out: C00};
    vecs[1] = '{vld: 2'b11, i0: Z64, k0: Z80, i1: F64, k1: F80, g: 1'b1, out: CFF};
    vecs[2] = '{vld: 2'b11, i0: Z64, k0: Z80, i1: F64, k1: F80, g: 1'b0, out: C00};
    vecs[3] = '{vld: 2'b10, i0: F64, k0: F80, i1: Z64, k1: F80, g: 1'b1, out: C0F};
    vecs[4] = '{vld: 2'b10, i0: Z64, k0: Z80, i1: F64, k1: Z80, g: 1'b1, out: CF0};
    vecs[5] = '{vld: 2'b11, i0: F64, k0: Z80, i1: Z64, k1: Z80, g: 1'b0, out: CF0};
    vecs[6] = '{vld: 2'b01, i0: Z64, k0: F80, i1: F64, k1: F80, g: 1'b0, out: C0F};
    vecs[7] = '{vld: 2'b11, i0: Z64, k0: Z80, i1: F64, k1: F80, g: 1'b1, out: CFF};

    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    check_reset_vals("reset");

    // Table: single job first, then alternating/solo mixes that exercise the pointer.
    for (int v = 0; v < 8; v++)
      run_job(vecs[v].vld, vecs[v].i0, vecs[v].k0, vecs[v].i1, vecs[v].k1,
              vecs[v].g, vecs[v].out, 1'b0, 0);

    // Both requesters held continuously after reset: served 0,1,0.
    rst = 1'b1; step(); rst = 1'b0;
    run_job(2'b11, Z64, Z80, F64, F80, 1'b0, C00, 1'b1, 0);
    run_job(2'b11, Z64, Z80, F64, F80, 1'b1, CFF, 1'b1, 0);
    run_job(2'b11, Z64, Z80, F64, F80, 1'b0, C00, 1'b1, 0);
    rq_vld = 2'b00;
    step();

    // Result backpressure for 20 cycles with a new request pending.
    run_job(2'b01, F64, F80, Z64, Z80, 1'b0, CFF, 1'b1, 20);
    rq_vld = 2'b00;
    step();

    // Reset five cycles after the start pulse drops the job.
    rq_vld = 2'b01; rq_inp0 = F64; rq_key0 = F80;
    #1;
    wait_accept(ok);
    if (!ok) fail("mid_accept");
    step();
    chk("mid_sta", cs_sta, 1'b1);
    rq_vld = 2'b00;
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_vals("mid_rst");
    run_job(2'b11, Z64, Z80, F64, F80, 1'b0, C00, 1'b0, 0);

    // Core that never answers.
    hang = 1'b1;
    rq_vld = 2'b01; rq_inp0 = Z64; rq_key0 = Z80;
    #1;
    wait_accept(ok);
    if (!ok) fail("hang_accept");
    step();
    rq_vld = 2'b00;
    step();
`ifdef PRESENT_ARB_TMO_EN
    repeat (39) step();
    chk("tmo_early_vld", rs_vld, 2'b00);
    chk("tmo_early_busy", busy, 1'b1);
    step();
    chk("tmo_vld", rs_vld, 2'b01);
    chk("tmo_err", rs_err, 1'b1);
    chk("tmo_out", rs_out, Z64);
    rs_rdy = 2'b01;
    step();
    rs_rdy = 2'b00;
    chk("tmo_err_clr", rs_err, 1'b0);
    chk("tmo_busy_clr", busy, 1'b0);
`else
    repeat (100) step();
    chk("hang_busy", busy, 1'b1);
    chk("hang_rs_vld", rs_vld, 2'b00);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("hang_rst_busy", busy, 1'b0);
`endif
    hang = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
